cp0_int_unit: RTL and testbench
===============================

# cp0_int_unit

Parametrised coprocessor-0 block for the pipelined MIPS core: holds SR, Cause, EPC and PRId, aggregates `N_INT` hardware interrupt lines with per-line edge or level capture, and decides exception/interrupt entry and `eret` return. It sits beside the M stage: it takes the M-stage instruction's PC and exception request, and drives the PC redirect and pipeline flush into the datapath. It generalises the fixed 6-line interrupt input of the current core, adding edge-latched lines and a configurable vector.

## Interface
- `N_INT`, 6, number of hardware interrupt lines; legal range 1..8.
- `EDGE_MASK`, `{N_INT{1'b0}}`, per-line mode: bit 1 = rising-edge latched, bit 0 = level.
- `EXC_VEC`, 32'h0000_4180, handler entry address.
- `PRID_VAL`, 32'h0000_0001, read-only PRId contents.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `hw_int` in N_INT: asynchronous device interrupt lines.
- `cp0_addr` in 5: register number for `mfc0`/`mtc0`.
- `cp0_we` in 1: `mtc0` write strobe, M stage.
- `cp0_wdata` in 32: `mtc0` data.
- `cp0_rdata` out 32: `mfc0` data (combinational).
- `pc_m` in 32: PC of the M-stage instruction.
- `bd_m` in 1: M-stage instruction is in a branch delay slot.
- `exc_valid_m` in 1: synchronous exception raised by the M-stage instruction.
- `exc_code_m` in 5: its ExcCode.
- `eret_m` in 1: `eret` in M stage.
- `take_exc` out 1: entry this cycle; flush F..M and redirect PC to `EXC_VEC` (combinational).
- `epc` out 32: current EPC, the target of `eret`.
- `int_pend` out 1: registered interrupt request.

## Operation

Registers:
- SR (12): IM = bits [N_INT+9:10], EXL = bit 1, IE = bit 0. All other bits read 0.
- Cause (13): BD = bit 31, IP = bits [N_INT+9:10], ExcCode = bits [6:2]. Cause is read-only to `mtc0`, except that writing 0 to an edge-mode IP bit clears it.
- EPC (14): read/write, with bits [1:0] forced to 0.
- PRId (15): reads `PRID_VAL`.
- Any other address reads 0; writes to it are ignored.

Interrupt capture:
- `hw_int` passes through a two-flop synchroniser, `s1` then `s2`.
- Level line: IP[i] <= s2[i] every cycle.
- Edge line: IP[i] is set when s2[i] is 1 and the previous s2[i] was 0. It holds until cleared by an `mtc0` to Cause. If a set and a clear land in the same cycle, the set wins.
- `int_pend` <= IE & ~EXL & |(IP & IM), registered.

Entry: `take_exc` = (`int_pend` | `exc_valid_m`) & ~reset.
- Interrupt has priority over the exception; ExcCode = 0 for an interrupt, otherwise `exc_code_m`.
- On entry, if EXL was 0: EPC <= `bd_m` ? `pc_m`-4 : `pc_m`, and BD <= `bd_m`.
- If EXL was 1 when the exception is taken, EPC and BD are unchanged.
- On every entry, EXL <= 1 and ExcCode is updated.

Return: `eret_m` with no entry in the same cycle sets EXL <= 0.

Simultaneous events:
- Entry and `mtc0` in the same cycle: the write is dropped.
- Entry and `eret_m` in the same cycle: entry wins.
- `eret_m` together with an `mtc0` to SR: IM and IE take the written value, EXL becomes 0.

## Timing
- Reset values: SR = 0, Cause = 0, EPC = 0, synchroniser flops = 0, `int_pend` = 0. Outputs follow from these, so `cp0_rdata` is 0 for address 12 and `take_exc` is 0.
- Interrupt latency: a `hw_int` rise sampled at edge t gives s2 at t+1, IP at t+2, and `int_pend` high during the cycle after edge t+3. `take_exc` asserts in that same cycle.
- `mtc0` takes effect at the next edge; `mfc0` of the same register in that cycle returns the old value.
- After entry, EXL = 1 from the next edge, so `int_pend` drops one cycle later. `take_exc` can therefore hold for at most one extra cycle; the datapath flush makes the repeat harmless.
- A reset mid-handler clears EXL and pending edge bits at the reset edge.

## Structure
- Shared package constants: CP0 register numbers (12..15), bit positions of IE, EXL, BD, IP/IM base and ExcCode field, ExcCode values (Int = 0, AdEL = 4, AdES = 5, RI = 10, Ov = 12).
- One sub-module, `int_sync_cap`: the synchroniser plus edge/level capture, parametrised by `N_INT` and `EDGE_MASK`.

## Test plan
- Reset, then read 12/13/14/15 -> values 0, 0, 0, 32'h1.
- Write SR = 32'h0000_0401 and hold level `hw_int[0]` = 1 -> `int_pend` and `take_exc` 4 cycles after the first sample edge; EPC = `pc_m`; ExcCode = 0; EXL = 1.
- `EDGE_MASK` = 6'b000010, pulse `hw_int[1]` for 1 cycle -> IP[11] stays 1. An `mtc0` to Cause with bit 11 = 0 clears it. A new edge on `hw_int[1]` in the clearing cycle leaves it at 1.
- `exc_valid_m` = 1, `exc_code_m` = 12, `bd_m` = 1, `pc_m` = 32'h3008 -> EPC = 32'h3004, BD = 1, ExcCode = 12. A second exception while EXL = 1 leaves EPC at 32'h3004.
- Interrupt and exception together -> ExcCode = 0. Entry together with `mtc0` EPC = 32'h1234 -> EPC holds the entry value, not 32'h1234.
- `eret_m` -> EXL = 0 and `epc` unchanged. A pending unmasked interrupt then re-enters 1 cycle later.

Source files
------------

// File: rtl/cp0_int_unit_pkg.sv
// Shared CP0 constants: register numbers, field positions and ExcCode values.
package cp0_int_unit_pkg;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam int SR_IE    = 0;
   localparam int SR_EXL   = 1;
   localparam int CAUSE_BD = 31;
   localparam int IP_BASE  = 10;
   localparam int EXC_LSB  = 2;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   // A delay-slot instruction restarts at its branch.
   function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
      return bd ? pc - 32'd4 : pc;
   endfunction

endpackage

// File: rtl/cp0_int_unit_int_sync_cap.sv
// Two-flop synchroniser plus per-line capture: level lines follow s2,
// edge lines latch a rising s2 until cleared (a new rise beats the clear).
module int_sync_cap #(
   parameter int               N_INT     = 6,
   parameter logic [N_INT-1:0] EDGE_MASK = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_INT-1:0] i_hw_int,
   input  logic [N_INT-1:0] i_clr,
   output logic [N_INT-1:0] o_ip
);

   logic [N_INT-1:0] r_s1, r_s2, r_s2_d, r_ip;
   logic [N_INT-1:0] w_ip_nxt;

   always_comb begin
      w_ip_nxt = '0;
      for (int i = 0; i < N_INT; i++)
         w_ip_nxt[i] = EDGE_MASK[i] ? ((r_ip[i] & ~i_clr[i]) | (r_s2[i] & ~r_s2_d[i]))
                                    : r_s2[i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_s2_d <= '0;
         r_ip   <= '0;
      end else begin
         r_s1   <= i_hw_int;
         r_s2   <= r_s1;
         r_s2_d <= r_s2;
         r_ip   <= w_ip_nxt;
      end
   end

   assign o_ip = r_ip;

endmodule

// File: rtl/cp0_int_unit.sv
// CP0 beside the M stage: SR/Cause/EPC/PRId, interrupt aggregation,
// exception/interrupt entry and eret return.
module cp0_int_unit
   import cp0_int_unit_pkg::*;
#(
   parameter int               N_INT     = 6,
   parameter logic [N_INT-1:0] EDGE_MASK = '0,
   parameter logic [31:0]      EXC_VEC   = 32'h0000_4180,
   parameter logic [31:0]      PRID_VAL  = 32'h0000_0001
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_INT-1:0] hw_int,
   input  logic [4:0]       cp0_addr,
   input  logic             cp0_we,
   input  logic [31:0]      cp0_wdata,
   output logic [31:0]      cp0_rdata,
   input  logic [31:0]      pc_m,
   input  logic             bd_m,
   input  logic             exc_valid_m,
   input  logic [4:0]       exc_code_m,
   input  logic             eret_m,
   output logic             take_exc,
   output logic [31:0]      epc,
   output logic             int_pend
);

   logic [N_INT-1:0] r_im, w_ip, w_clr;
   logic             r_ie, r_exl, r_bd, r_int_pend;
   logic [4:0]       r_code;
   logic [31:0]      r_epc;
   logic             w_wr_sr, w_wr_cause, w_wr_epc;
   logic [31:0]      w_sr, w_cause;
   logic [31:0]      w_unused_vec;

   // The redirect target is applied in the datapath; only the parameter lives here.
   assign w_unused_vec = EXC_VEC;

   assign take_exc   = (r_int_pend | exc_valid_m) & ~reset;
   assign w_wr_sr    = cp0_we & (cp0_addr == CP0_SR);
   assign w_wr_cause = cp0_we & (cp0_addr == CP0_CAUSE);
   assign w_wr_epc   = cp0_we & (cp0_addr == CP0_EPC);
   assign w_clr      = (w_wr_cause & ~take_exc) ? (~cp0_wdata[IP_BASE +: N_INT] & EDGE_MASK) : '0;

   int_sync_cap #(.N_INT(N_INT), .EDGE_MASK(EDGE_MASK)) u_cap (
      .clk      (clk),
      .reset    (reset),
      .i_hw_int (hw_int),
      .i_clr    (w_clr),
      .o_ip     (w_ip)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_im       <= '0;
         r_ie       <= 1'b0;
         r_exl      <= 1'b0;
         r_bd       <= 1'b0;
         r_code     <= '0;
         r_epc      <= '0;
         r_int_pend <= 1'b0;
      end else begin
         r_int_pend <= r_ie & ~r_exl & (|(w_ip & r_im));
         if (take_exc) begin
            // Nested entry keeps the original return point.
            if (!r_exl) begin
               r_epc <= epc_target(pc_m, bd_m);
               r_bd  <= bd_m;
            end
            r_exl  <= 1'b1;
            r_code <= r_int_pend ? EXC_INT : exc_code_m;
         end else begin
            if (w_wr_sr) begin
               r_im  <= cp0_wdata[IP_BASE +: N_INT];
               r_ie  <= cp0_wdata[SR_IE];
               r_exl <= cp0_wdata[SR_EXL];
            end
            if (w_wr_epc) r_epc <= {cp0_wdata[31:2], 2'b00};
            if (eret_m)   r_exl <= 1'b0;
         end
      end
   end

   always_comb begin
      w_sr                   = '0;
      w_sr[IP_BASE +: N_INT] = r_im;
      w_sr[SR_EXL]           = r_exl;
      w_sr[SR_IE]            = r_ie;
      w_cause                     = '0;
      w_cause[CAUSE_BD]           = r_bd;
      w_cause[IP_BASE +: N_INT]   = w_ip;
      w_cause[EXC_LSB +: 5]       = r_code;
      case (cp0_addr)
         CP0_SR:    cp0_rdata = w_sr;
         CP0_CAUSE: cp0_rdata = w_cause;
         CP0_EPC:   cp0_rdata = r_epc;
         CP0_PRID:  cp0_rdata = PRID_VAL;
         default:   cp0_rdata = '0;
      endcase
   end

   assign epc      = r_epc;
   assign int_pend = r_int_pend;

endmodule

// File: tb/tb_cp0_int_unit.sv
// Bench for cp0_int_unit: directed scenarios plus a randomized run, all checked
// against a cycle-level reference model of the CP0 rules.
module tb_cp0_int_unit;

   localparam int             N  = 6;
   localparam logic [N-1:0]   EM = 6'b000010;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  hw_int;
   logic [4:0]    cp0_addr;
   logic          cp0_we;
   logic [31:0]   cp0_wdata, cp0_rdata;
   logic [31:0]   pc_m;
   logic          bd_m, exc_valid_m, eret_m;
   logic [4:0]    exc_code_m;
   logic          take_exc, int_pend;
   logic [31:0]   epc;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cp0_int_unit #(.N_INT(N), .EDGE_MASK(EM)) dut (
      .clk         (clk),
      .reset       (reset),
      .hw_int      (hw_int),
      .cp0_addr    (cp0_addr),
      .cp0_we      (cp0_we),
      .cp0_wdata   (cp0_wdata),
      .cp0_rdata   (cp0_rdata),
      .pc_m        (pc_m),
      .bd_m        (bd_m),
      .exc_valid_m (exc_valid_m),
      .exc_code_m  (exc_code_m),
      .eret_m      (eret_m),
      .take_exc    (take_exc),
      .epc         (epc),
      .int_pend    (int_pend)
   );

   // Reference state; hist[k] is hw_int as sampled k+1 edges ago.
   logic [N-1:0] hist [3];
   logic [N-1:0] m_ip, m_im;
   logic         m_ie, m_exl, m_bd, m_pend;
   logic [4:0]   m_code;
   logic [31:0]  m_epc;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      logic [31:0] v;
      v = '0;
      case (a)
         5'd12: begin v[15:10] = m_im; v[1] = m_exl; v[0] = m_ie; end
         5'd13: begin v[31] = m_bd; v[15:10] = m_ip; v[6:2] = m_code; end
         5'd14: v = m_epc;
         5'd15: v = 32'h1;
         default: v = '0;
      endcase
      return v;
   endfunction

   function automatic logic m_take();
      return (m_pend | exc_valid_m) & ~reset;
   endfunction

   task automatic model_edge();
      logic         take, npend;
      logic [N-1:0] rise, clr, nip;
      if (reset) begin
         m_ip = '0; m_im = '0; m_ie = 0; m_exl = 0; m_bd = 0; m_pend = 0;
         m_code = '0; m_epc = '0;
         hist[0] = '0; hist[1] = '0; hist[2] = '0;
      end else begin
         take  = m_pend | exc_valid_m;
         rise  = hist[1] & ~hist[2];
         clr   = (cp0_we && cp0_addr == 5'd13 && !take) ? (~cp0_wdata[15:10] & EM) : '0;
         nip   = (EM & ((m_ip & ~clr) | rise)) | (~EM & hist[1]);
         npend = m_ie && !m_exl && ((m_ip & m_im) != 0);
         if (take) begin
            if (!m_exl) begin
               m_epc = bd_m ? pc_m - 32'd4 : pc_m;
               m_bd  = bd_m;
            end
            m_exl  = 1'b1;
            m_code = m_pend ? 5'd0 : exc_code_m;
         end else begin
            if (cp0_we && cp0_addr == 5'd12) begin
               m_im = cp0_wdata[15:10]; m_ie = cp0_wdata[0]; m_exl = cp0_wdata[1];
            end
            if (cp0_we && cp0_addr == 5'd14) m_epc = {cp0_wdata[31:2], 2'b00};
            if (eret_m) m_exl = 1'b0;
         end
         m_ip   = nip;
         m_pend = npend;
         hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = hw_int;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      cp0_we = 0; cp0_addr = '0; cp0_wdata = '0; exc_valid_m = 0;
      exc_code_m = '0; eret_m = 0; bd_m = 0;
   endtask

   task automatic do_reset();
      reset = 1; idle(); hw_int = '0; pc_m = '0;
      cyc(); cyc();
      reset = 0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      cp0_we = 1; cp0_addr = a; cp0_wdata = d;
      cyc();
      idle();
   endtask

   task automatic test_reset();
      logic [31:0] exp [4];
      exp[0] = 32'h0; exp[1] = 32'h0; exp[2] = 32'h0; exp[3] = 32'h1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cp0_addr = 5'(12 + i); #1;
         checks++;
         if (cp0_rdata !== exp[i]) begin
            errors++; $display("FAIL reset_read%0d: got %h want %h", 12 + i, cp0_rdata, exp[i]);
         end
      end
      checks++;
      if (take_exc !== 1'b0 || int_pend !== 1'b0) begin
         errors++; $display("FAIL reset_outs: take=%b pend=%b want 0 0", take_exc, int_pend);
      end
   endtask

   task automatic test_level_int();
      do_reset();
      pc_m = 32'h2000;
      mtc0(5'd12, 32'h0000_0401);
      hw_int = 6'b000001;
      cyc(); cyc(); cyc();
      checks++;
      if (int_pend !== 1'b0 || take_exc !== 1'b0) begin
         errors++; $display("FAIL level_early: pend=%b take=%b want 0 0", int_pend, take_exc);
      end
      cyc();
      checks++;
      if (int_pend !== 1'b1 || take_exc !== 1'b1) begin
         errors++; $display("FAIL level_pend: pend=%b take=%b want 1 1", int_pend, take_exc);
      end
      cyc();
      cp0_addr = 5'd14; #1;
      checks++;
      if (cp0_rdata !== 32'h2000) begin
         errors++; $display("FAIL level_epc: got %h want 00002000", cp0_rdata);
      end
      cp0_addr = 5'd13; #1;
      checks++;
      if (cp0_rdata[6:2] !== 5'd0) begin
         errors++; $display("FAIL level_code: got %0d want 0", cp0_rdata[6:2]);
      end
      cp0_addr = 5'd12; #1;
      checks++;
      if (cp0_rdata[1] !== 1'b1) begin
         errors++; $display("FAIL level_exl: got %b want 1", cp0_rdata[1]);
      end
   endtask

   task automatic test_edge();
      do_reset();
      hw_int = 6'b000010; cyc();
      hw_int = '0;
      for (int i = 0; i < 6; i++) cyc();
      cp0_addr = 5'd13; #1;
      checks++;
      if (cp0_rdata[11] !== 1'b1) begin
         errors++; $display("FAIL edge_hold: ip11=%b want 1", cp0_rdata[11]);
      end
      mtc0(5'd13, 32'h0);
      cp0_addr = 5'd13; #1;
      checks++;
      if (cp0_rdata[11] !== 1'b0) begin
         errors++; $display("FAIL edge_clear: ip11=%b want 0", cp0_rdata[11]);
      end
      hw_int = 6'b000010; cyc();
      hw_int = '0; cyc();
      mtc0(5'd13, 32'h0);
      cp0_addr = 5'd13; #1;
      checks++;
      if (cp0_rdata[11] !== 1'b1 || cp0_rdata !== m_read(5'd13)) begin
         errors++; $display("FAIL edge_set_wins: cause=%h want bit11 set, model %h", cp0_rdata, m_read(5'd13));
      end
   endtask

   task automatic test_exc();
      do_reset();
      pc_m = 32'h3008; bd_m = 1; exc_valid_m = 1; exc_code_m = 5'd12; #1;
      checks++;
      if (take_exc !== 1'b1) begin
         errors++; $display("FAIL exc_take: got %b want 1", take_exc);
      end
      cyc(); idle();
      cp0_addr = 5'd13; #1;
      checks++;
      if (epc !== 32'h3004 || cp0_rdata !== 32'h8000_0030) begin
         errors++; $display("FAIL exc_entry: epc=%h cause=%h want 00003004 80000030", epc, cp0_rdata);
      end
      pc_m = 32'h5000; bd_m = 0; exc_valid_m = 1; exc_code_m = 5'd4;
      cyc(); idle();
      cp0_addr = 5'd13; #1;
      checks++;
      if (epc !== 32'h3004 || cp0_rdata !== 32'h8000_0010) begin
         errors++; $display("FAIL exc_nested: epc=%h cause=%h want 00003004 80000010", epc, cp0_rdata);
      end
   endtask

   task automatic test_simul_and_eret();
      do_reset();
      pc_m = 32'h6000;
      mtc0(5'd12, 32'h0000_0401);
      hw_int = 6'b000001;
      cyc(); cyc(); cyc(); cyc();
      exc_valid_m = 1; exc_code_m = 5'd10; cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'h1234;
      cyc(); idle();
      cyc();
      cp0_addr = 5'd13; #1;
      checks++;
      if (epc !== 32'h6000 || cp0_rdata[6:2] !== 5'd0 || int_pend !== 1'b0) begin
         errors++; $display("FAIL simul: epc=%h code=%0d pend=%b want 00006000 0 0", epc, cp0_rdata[6:2], int_pend);
      end
      eret_m = 1; cp0_addr = 5'd12; #1;
      checks++;
      if (take_exc !== 1'b0 || cp0_rdata !== 32'h403) begin
         errors++; $display("FAIL eret_pre: take=%b sr=%h want 0 00000403", take_exc, cp0_rdata);
      end
      cyc(); idle();
      cp0_addr = 5'd12; #1;
      checks++;
      if (cp0_rdata !== 32'h401 || epc !== 32'h6000 || int_pend !== 1'b0) begin
         errors++; $display("FAIL eret: sr=%h epc=%h pend=%b want 00000401 00006000 0", cp0_rdata, epc, int_pend);
      end
      cyc();
      checks++;
      if (int_pend !== 1'b1 || take_exc !== 1'b1) begin
         errors++; $display("FAIL reenter: pend=%b take=%b want 1 1", int_pend, take_exc);
      end
      hw_int = '0;
      for (int i = 0; i < 6; i++) cyc();
      eret_m = 1; cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0803;
      cyc(); idle();
      cp0_addr = 5'd12; #1;
      checks++;
      if (cp0_rdata !== 32'h801) begin
         errors++; $display("FAIL eret_mtc0: sr=%h want 00000801", cp0_rdata);
      end
   endtask

   task automatic test_random();
      logic [4:0] codes [4];
      codes[0] = 5'd4; codes[1] = 5'd5; codes[2] = 5'd10; codes[3] = 5'd12;
      do_reset();
      for (int n = 0; n < 800; n++) begin
         reset       = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0) hw_int = N'($urandom);
         exc_valid_m = ($urandom_range(0, 9) == 0);
         exc_code_m  = codes[$urandom_range(0, 3)];
         eret_m      = ($urandom_range(0, 9) == 0);
         cp0_we      = ($urandom_range(0, 3) == 0);
         cp0_addr    = 5'($urandom_range(10, 17));
         cp0_wdata   = $urandom;
         pc_m        = $urandom;
         bd_m        = 1'($urandom);
         #1;
         checks++;
         if (take_exc !== m_take() || int_pend !== m_pend || epc !== m_epc
             || cp0_rdata !== m_read(cp0_addr)) begin
            errors++;
            $display("FAIL rand[%0d]: take=%b/%b pend=%b/%b epc=%h/%h rd(%0d)=%h/%h (got/want)",
                     n, take_exc, m_take(), int_pend, m_pend, epc, m_epc,
                     cp0_addr, cp0_rdata, m_read(cp0_addr));
         end
         cyc();
      end
      reset = 0;
   endtask

   initial begin
      reset = 1; idle(); hw_int = '0; pc_m = '0;
      test_reset();
      test_level_int();
      test_edge();
      test_exc();
      test_simul_and_eret();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
